// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle control unit.
// Opcode values, FSM state encoding and PC source selects.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
  } state_e;

  // R-class opcodes span OP_ADD..OP_SHL; opcodes above OP_JMP are illegal.
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_ST  = 4'd6;
  localparam logic [3:0] OP_LD  = 4'd7;
  localparam logic [3:0] OP_SLI = 4'd8;
  localparam logic [3:0] OP_BR  = 4'd9;
  localparam logic [3:0] OP_JMP = 4'd10;

  localparam logic [1:0] PC_SRC_INC = 2'd0;
  localparam logic [1:0] PC_SRC_BR  = 2'd1;
  localparam logic [1:0] PC_SRC_JMP = 2'd2;

  function automatic logic is_rclass(input logic [3:0] op);
    return op <= OP_SHL;
  endfunction

  function automatic logic uses_imm(input logic [3:0] op);
    return (op == OP_LD) || (op == OP_ST) || (op == OP_SLI);
  endfunction

endpackage

// File: rtl/mc_mem_timeout.sv
// Memory wait watchdog: counts stalled request cycles and pulses expire
// on the cycle the count would reach 2^TO_W-1.
module mc_mem_timeout #(
  parameter int TO_W = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam logic [TO_W-1:0] LAST = TO_W'((2 ** TO_W) - 2);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  assign expire_o = enable_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || expire_o) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/write-back,
// drives datapath enables and reports retirement and error pulses.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int TO_W     = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                iord,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                alu_src,
  output logic [3:0]          alu_op,
  output logic                reg_wr,
  output logic                reg_dst,
  output logic                mem2reg,
  output logic [2:0]          state,
  output logic                instr_done,
  output logic                illegal,
  output logic                bus_err
);

  state_e     state_q, state_d;
  logic [3:0] op_q, op_d;
  logic       req_w;
  logic       to_clear_w;
  logic       to_enable_w;
  logic       expire_w;
  logic       op_legal_w;

  assign state = state_q;

  // Request is a pure function of state, so the watchdog has no path back into it.
  assign req_w       = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign mem_req     = req_w;
  assign to_clear_w  = !req_w || mem_ready;
  assign to_enable_w = req_w && !mem_ready;

  assign op_legal_w = ((opcode >> 4) == '0) && (opcode[3:0] <= OP_JMP);

  mc_mem_timeout #(
    .TO_W(TO_W)
  ) u_timeout (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clear_i (to_clear_w),
    .enable_i(to_enable_w),
    .expire_o(expire_w)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_SRC_INC;
    alu_src    = 1'b0;
    alu_op     = OP_ADD;
    reg_wr     = 1'b0;
    reg_dst    = 1'b0;
    mem2reg    = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    bus_err    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end else if (expire_w) begin
          bus_err = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        op_d = opcode[3:0];
        if (!op_legal_w) begin
          illegal = 1'b1;
          state_d = ST_FETCH;
        end else if (opcode[3:0] == OP_JMP) begin
          pc_write   = 1'b1;
          pc_src     = PC_SRC_JMP;
          instr_done = 1'b1;
          state_d    = ST_FETCH;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_src = uses_imm(op_q);
        alu_op  = is_rclass(op_q) ? op_q : OP_ADD;
        if (op_q == OP_BR) begin
          alu_op     = OP_SUB;
          pc_write   = zero;
          pc_src     = PC_SRC_BR;
          instr_done = 1'b1;
          state_d    = ST_FETCH;
        end else if ((op_q == OP_LD) || (op_q == OP_ST)) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        iord   = 1'b1;
        mem_we = (op_q == OP_ST);
        if (mem_ready) begin
          if (op_q == OP_ST) begin
            instr_done = 1'b1;
            state_d    = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (expire_w) begin
          bus_err = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_WB: begin
        reg_wr     = 1'b1;
        reg_dst    = is_rclass(op_q);
        mem2reg    = (op_q == OP_LD);
        instr_done = 1'b1;
        state_d    = ST_FETCH;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ADD;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Multicycle control unit for the 4-bit-opcode MIPS-style core: a Moore/Mealy state machine that sequences each instruction through fetch, decode, execute, memory and write-back, driving datapath enables one state at a time. It handshakes with a single shared instruction/data memory, bounds every memory wait with a timeout counter, and flags illegal opcodes. It sits between the instruction register/memory port and the single-cycle-style datapath (register file, ALU, PC mux).

## Interface
- OPCODE_W, 4, opcode width (≥4; bits above [3:0] must be zero, else illegal)
- TO_W, 4, timeout counter width; memory wait limit = 2^TO_W−1 cycles
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- opcode  in  OPCODE_W  opcode field of instruction register output
- zero  in  1  ALU zero flag (branch condition)
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory request valid
- mem_we  out  1  write strobe (qualifies mem_req)
- iord  out  1  address select: 0 = PC, 1 = ALU result
- ir_write  out  1  load instruction register
- pc_write  out  1  load PC
- pc_src  out  2  0 = PC+1, 1 = branch target, 2 = jump target
- alu_src  out  1  0 = register, 1 = immediate
- alu_op  out  4  ALU function (= opcode for ALU class, 0 = add otherwise)
- reg_wr, reg_dst, mem2reg  out  1 each  register-file write, rd select, load-data select
- state  out  3  current state (debug)
- instr_done  out  1  one-cycle pulse on instruction retirement
- illegal, bus_err  out  1 each  one-cycle error pulses

## Operation
- Opcodes: ADD 0, SUB 1, LT 2, OR 3, AND 4, SHL 5, ST 6, LD 7, SLI 8, BR 9, JMP 10; 11–15 illegal. R-class = 0–5.
- States: IDLE 0, FETCH 1, DECODE 2, EXEC 3, MEM 4, WB 5; 6–7 unreachable, decode to IDLE.
- IDLE: all outputs 0; → FETCH.
- FETCH: mem_req=1, iord=0. On mem_ready: ir_write=1, pc_write=1, pc_src=0, → DECODE.
- DECODE: opcode sampled into op_q. JMP: pc_write=1, pc_src=2, instr_done=1, → FETCH. Illegal: illegal=1, → FETCH (no retire). Else → EXEC.
- EXEC: alu_op/alu_src from op_q (alu_src=1 for LD, ST, SLI). BR: alu_op=SUB, pc_write=zero, pc_src=1, instr_done=1, → FETCH. LD/ST → MEM. R-class/SLI → WB.
- MEM: mem_req=1, iord=1, mem_we=(op_q==ST). On mem_ready: ST → FETCH with instr_done=1; LD → WB.
- WB: reg_wr=1, reg_dst=R-class, mem2reg=LD; instr_done=1; → FETCH.
- Timeout: counter clears on entry to FETCH/MEM and on mem_ready; increments each cycle mem_req=1 && !mem_ready. On reaching 2^TO_W−1 without mem_ready: bus_err=1; FETCH re-enters FETCH (PC unchanged); MEM aborts to FETCH, no write-back, no instr_done.
- Outputs not listed for a state are 0.

## Timing
- Reset (async assert, sync release): state=IDLE, op_q=0, counter=0; all outputs 0.
- Latency with zero-wait memory (mem_ready in first request cycle): JMP 2, BR 3, R-class/SLI/ST 4, LD 5 cycles from FETCH entry to instr_done; each memory wait cycle adds 1.
- state, op_q, counter registered; control outputs combinational from state, op_q, zero, mem_ready.
- mem_ready with mem_req=0 is ignored. mem_ready on the timeout cycle wins (no bus_err).
- Reset mid-instruction: immediate return to IDLE, no pulses emitted.

## Structure
- Package mc_ctrl_pkg: state enum, opcode localparams, pc_src encodings.
- Sub-module mc_mem_timeout (TO_W): clear/enable inputs, expire output.

## Test plan
- Reset then zero-wait ADD (opcode 0): IDLE→FETCH→DECODE→EXEC→WB; reg_wr=1, reg_dst=1 in WB; instr_done at cycle 5 after rst_n release.
- LD (7) with mem_ready delayed 3 cycles in MEM: mem_req, iord=1 held 4 cycles; WB has mem2reg=1, reg_wr=1; total latency 8.
- BR (9) with zero=1 then zero=0: pc_write=1, pc_src=1 in EXEC only when zero=1; instr_done both cases.
- Opcode 12: illegal pulses in DECODE, next state FETCH, no instr_done, no reg_wr.
- TO_W=4, ST with mem_ready never asserted: bus_err after 15 wait cycles, next FETCH, mem_we dropped, no instr_done.
- rst_n asserted mid-MEM of LD: outputs 0 asynchronously, state=IDLE, no reg_wr follows.
